// File: rtl/rom_access_arbiter_if.sv
// Request/grant/response bundle between the compute units, the arbiter and the ROM.
// master = requesters plus ROM side, slave = arbiter.
interface rom_access_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 7,
    parameter int DW   = 20
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic [AW-1:0]      rom_addr;
    logic [DW-1:0]      rom_data;
    logic               busy;

    modport master (
        output req, req_addr, rom_data,
        input  gnt, rsp_valid, rsp_data, rom_addr, busy
    );

    modport slave (
        input  req, req_addr, rom_data,
        output gnt, rsp_valid, rsp_data, rom_addr, busy
    );
endinterface

// File: rtl/rom_access_arbiter.sv
// Round-robin sharing of one registered-read ROM; gnt -> rsp_valid latency ROM_LAT+1 cycles.
// No backpressure: requesters hold req/addr until gnt, responses are always accepted.
module rom_access_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 7,
    parameter int DW      = 20,
    parameter int ROM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rom_access_arbiter_if.slave   bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]   ptr;
    logic [AW-1:0]   addr_q;
    logic [IW-1:0]   gidx;
    logic            found;
    logic            grant_vld;
    logic [NREQ-1:0] gnt_c;

    logic [ROM_LAT-1:0] tag_vld;
    logic [IW-1:0]      tag_idx [ROM_LAT];
    logic [NREQ-1:0]    rsp_valid_q;
    logic [DW-1:0]      rsp_data_q;

    // Search from ptr upward with wrap; first asserted req wins.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            int cand;
            cand = int'(ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && bus.req[cand[IW-1:0]]) begin
                found = 1'b1;
                gidx  = cand[IW-1:0];
            end
        end
    end

    // Gated by rst_n so an asserted reset suppresses grants immediately.
    assign grant_vld = found & rst_n;

    always_comb begin
        gnt_c = '0;
        if (grant_vld) gnt_c[gidx] = 1'b1;
    end

    assign bus.gnt       = gnt_c;
    assign bus.rom_addr  = grant_vld ? bus.req_addr[int'(gidx)*AW +: AW] : addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = (|tag_vld) | (|rsp_valid_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            addr_q      <= '0;
            tag_vld     <= '0;
            for (int s = 0; s < ROM_LAT; s++) tag_idx[s] <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            if (grant_vld) begin
                ptr    <= (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;
                addr_q <= bus.rom_addr;
            end

            // Tag pipeline tracks which requester owns the word emerging from the ROM.
            tag_vld[0] <= grant_vld;
            tag_idx[0] <= gidx;
            for (int s = 1; s < ROM_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end

            rsp_valid_q <= '0;
            if (tag_vld[ROM_LAT-1]) begin
                rsp_valid_q[tag_idx[ROM_LAT-1]] <= 1'b1;
                rsp_data_q                      <= bus.rom_data;
            end
        end
    end
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Three arbiters (ROM_LAT 1,2,3) share one request stream; a round-robin model
// predicts grants and a scoreboard per instance checks responses and busy.
module tb_rom_access_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 7;
    localparam int DW   = 20;
    localparam int NI   = 3;

    typedef struct packed {
        int            idx;
        logic [DW-1:0] data;
        int            g;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0]      mem [128];
    logic [NREQ-1:0]    req_d = '0;
    logic [NREQ*AW-1:0] addr_d = '0;

    logic [NREQ-1:0] gnt_w [NI];
    logic [NREQ-1:0] rv_w  [NI];
    logic [DW-1:0]   rd_w  [NI];
    logic [AW-1:0]   ra_w  [NI];
    logic            bz_w  [NI];

    for (genvar j = 0; j < NI; j++) begin : g_inst
        localparam int LAT = j + 1;
        rom_access_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) ifc ();
        logic [AW-1:0] apipe [LAT];

        initial for (int s = 0; s < LAT; s++) apipe[s] = '0;
        always @(posedge clk) begin
            apipe[0] <= ifc.rom_addr;
            for (int s = 1; s < LAT; s++) apipe[s] <= apipe[s-1];
        end

        assign ifc.req      = req_d;
        assign ifc.req_addr = addr_d;
        assign ifc.rom_data = mem[apipe[LAT-1]];

        rom_access_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(LAT)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc.slave)
        );

        assign gnt_w[j] = ifc.gnt;
        assign rv_w[j]  = ifc.rsp_valid;
        assign rd_w[j]  = ifc.rsp_data;
        assign ra_w[j]  = ifc.rom_addr;
        assign bz_w[j]  = ifc.busy;
    end

    int vectors = 0;
    int errors  = 0;

    exp_t          q [NI][$];
    int            ptr_m = 0;
    logic [AW-1:0] last_a = '0;
    logic [DW-1:0] last_d [NI];
    logic          mon_en = 1'b0;
    logic          pend  [NREQ];
    logic [AW-1:0] paddr [NREQ];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_model();
        ptr_m  = 0;
        last_a = '0;
        for (int j = 0; j < NI; j++) begin
            q[j].delete();
            last_d[j] = '0;
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    endtask

    // Drive one cycle of requests, check grant and ROM address, queue expected responses.
    task automatic do_cycle(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a, output int g);
        logic [NREQ-1:0] eg;
        logic [AW-1:0]   ea;
        @(negedge clk);
        req_d  = r;
        addr_d = a;
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr_m + k) % NREQ;
            if (g < 0 && r[i]) g = i;
        end
        eg = '0;
        ea = last_a;
        if (g >= 0) begin
            eg[g] = 1'b1;
            ea    = a[g*AW +: AW];
        end
        for (int j = 0; j < NI; j++) begin
            chk($sformatf("gnt[lat%0d]", j+1), 32'(gnt_w[j]), 32'(eg));
            chk($sformatf("rom_addr[lat%0d]", j+1), 32'(ra_w[j]), 32'(ea));
        end
        if (g >= 0) begin
            ptr_m  = (g + 1) % NREQ;
            last_a = ea;
            for (int j = 0; j < NI; j++)
                q[j].push_back('{idx: g, data: mem[ea], g: cyc, due: cyc + j + 2});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_d = '1;
        rst_n = 1'b0;
        #1;
        clear_model();
        for (int j = 0; j < NI; j++) begin
            chk($sformatf("rst_gnt[lat%0d]", j+1), 32'(gnt_w[j]), 32'd0);
            chk($sformatf("rst_rsp_valid[lat%0d]", j+1), 32'(rv_w[j]), 32'd0);
            chk($sformatf("rst_busy[lat%0d]", j+1), 32'(bz_w[j]), 32'd0);
        end
        req_d = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic random_phase(input int n);
        int g;
        logic [NREQ-1:0]    r;
        logic [NREQ*AW-1:0] a;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        pend[i]  = 1'b1;
                        paddr[i] = AW'($urandom);
                    end
                end else if ($urandom_range(15, 0) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            r = '0;
            a = '0;
            for (int i = 0; i < NREQ; i++) begin
                r[i]          = pend[i];
                a[i*AW +: AW] = paddr[i];
            end
            do_cycle(r, a, g);
            if (g >= 0) pend[g] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        int g;
        for (int c = 0; c < n; c++) do_cycle('0, '0, g);
    endtask

    // Monitor: compares registered outputs against the scoreboard every cycle.
    always @(negedge clk) begin
        logic [NREQ-1:0] ev;
        logic [DW-1:0]   ed;
        logic            eb;
        #2;
        if (mon_en) begin
            for (int j = 0; j < NI; j++) begin
                eb = (q[j].size() > 0) && (q[j][0].g < cyc);
                ev = '0;
                ed = last_d[j];
                if (q[j].size() > 0 && q[j][0].due == cyc) begin
                    ev        = NREQ'(1) << q[j][0].idx;
                    ed        = q[j][0].data;
                    last_d[j] = ed;
                    void'(q[j].pop_front());
                end
                chk($sformatf("rsp_valid[lat%0d]", j+1), 32'(rv_w[j]), 32'(ev));
                chk($sformatf("rsp_data[lat%0d]", j+1), 32'(rd_w[j]), 32'(ed));
                chk($sformatf("busy[lat%0d]", j+1), 32'(bz_w[j]), 32'(eb));
            end
        end
    end

    initial begin
        int g;
        int k;
        logic [NREQ*AW-1:0] a;
        for (int i = 0; i < 128; i++) mem[i] = DW'($urandom);
        mem[5] = 20'hA5A5A;
        clear_model();
        #1;
        rst_n  = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single read by requester 2 from word 5.
        a = '0;
        a[2*AW +: AW] = 7'h05;
        do_cycle(4'b0100, a, g);
        idle(6);

        // All requesters held with addresses 0..3: strict rotation.
        a = '0;
        for (int i = 0; i < NREQ; i++) a[i*AW +: AW] = AW'(i);
        for (int c = 0; c < 12; c++) do_cycle('1, a, g);
        idle(6);

        // Pointer wrap: grant 3, then 0 and 3 compete.
        a = '0;
        a[3*AW +: AW] = 7'h33;
        a[0*AW +: AW] = 7'h11;
        do_cycle(4'b1000, a, g);
        do_cycle(4'b1001, a, g);
        do_cycle(4'b1000, a, g);
        idle(6);

        // Back-to-back from requester 1, address steps on each grant.
        k = 0;
        for (int c = 0; c < 16 && k < 8; c++) begin
            a = '0;
            a[1*AW +: AW] = AW'(k);
            do_cycle(4'b0010, a, g);
            if (g == 1) k++;
        end
        idle(6);

        random_phase(300);
        do_reset();
        random_phase(300);
        idle(8);

        for (int j = 0; j < NI; j++)
            chk($sformatf("drain[lat%0d]", j+1), 32'(q[j].size()), 32'd0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
